// File: rtl/param_sequence_detector_if.sv
// Bus bundle between the serial bit source/configuration side and the sequence detector.
// SEQ_DET_MASK_EN adds the per-bit pattern mask.
interface param_sequence_detector_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
);
    logic               j;
    logic               j_valid;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic               overlap;
    logic               one_shot;
    logic               co;
`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] pat_mask;
`endif
    logic               w;
    logic               init;
    logic               en;
    logic [CNT_W-1:0]   match_cnt;

`ifdef SEQ_DET_MASK_EN
    modport master (
        output j, j_valid, pat_load, pat_in, len_in, overlap, one_shot, co, pat_mask,
        input  w, init, en, match_cnt
    );
    modport slave (
        input  j, j_valid, pat_load, pat_in, len_in, overlap, one_shot, co, pat_mask,
        output w, init, en, match_cnt
    );
`else
    modport master (
        output j, j_valid, pat_load, pat_in, len_in, overlap, one_shot, co,
        input  w, init, en, match_cnt
    );
    modport slave (
        input  j, j_valid, pat_load, pat_in, len_in, overlap, one_shot, co,
        output w, init, en, match_cnt
    );
`endif
endinterface

// File: rtl/param_sequence_detector.sv
// Programmable serial sequence detector: run-time pattern/length, overlap and one-shot modes,
// saturating match counter. Optional macro SEQ_DET_MASK_EN enables per-bit don't-care masking.
module param_sequence_detector #(
    parameter int unsigned        MAX_LEN = 8,
    parameter int unsigned        LEN_W   = 4,
    parameter int unsigned        CNT_W   = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0001_0110),
    parameter int unsigned        DEF_LEN = 5
) (
    input logic clk,
    input logic rst,
    param_sequence_detector_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);

    typedef enum logic {
        ARMED = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [MAX_LEN-1:0] hist, hist_nxt;
    logic [FILL_W-1:0]  fill, fill_nxt;
    logic [MAX_LEN-1:0] pat, pat_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               w_nxt;
`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] mask, mask_nxt;
`endif

    logic [MAX_LEN-1:0] hist_sh;
    logic [FILL_W-1:0]  fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] diff;
    logic [LEN_W-1:0]   len_clamp;
    logic               hit;

    // Candidate history/fill after accepting the current bit, and the match test on it
    always_comb begin
        hist_sh  = {hist[MAX_LEN-2:0], bus.j};
        fill_inc = (fill == FILL_W'(MAX_LEN)) ? fill : fill + FILL_W'(1);
        len_mask = ~({MAX_LEN{1'b1}} << len);
`ifdef SEQ_DET_MASK_EN
        diff     = (hist_sh ^ pat) & mask & len_mask;
`else
        diff     = (hist_sh ^ pat) & len_mask;
`endif
        hit      = (state == ARMED) && (32'(fill_inc) >= 32'(len)) && (diff == '0);

        if (bus.len_in == '0)
            len_clamp = LEN_W'(1);
        else if (32'(bus.len_in) > MAX_LEN)
            len_clamp = LEN_W'(MAX_LEN);
        else
            len_clamp = bus.len_in;
    end

    // Next-state logic: pat_load beats co beats an accepted bit
    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        fill_nxt  = fill;
        pat_nxt   = pat;
        len_nxt   = len;
        cnt_nxt   = cnt;
        w_nxt     = 1'b0;
`ifdef SEQ_DET_MASK_EN
        mask_nxt  = mask;
`endif
        if (bus.pat_load) begin
            pat_nxt   = bus.pat_in;
            len_nxt   = len_clamp;
            hist_nxt  = '0;
            fill_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = ARMED;
`ifdef SEQ_DET_MASK_EN
            mask_nxt  = bus.pat_mask;
`endif
        end else if (bus.co) begin
            hist_nxt  = '0;
            fill_nxt  = '0;
            state_nxt = ARMED;
        end else if (bus.j_valid && (state == ARMED)) begin
            hist_nxt = hist_sh;
            fill_nxt = fill_inc;
            if (hit) begin
                w_nxt   = 1'b1;
                cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
                if (!bus.overlap)
                    fill_nxt = '0;
                if (bus.one_shot)
                    state_nxt = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ARMED;
            hist          <= '0;
            fill          <= '0;
            pat           <= DEF_PAT;
            len           <= LEN_W'(DEF_LEN);
            cnt           <= '0;
`ifdef SEQ_DET_MASK_EN
            mask          <= '1;
`endif
            bus.w         <= 1'b0;
            bus.init      <= 1'b0;
            bus.en        <= 1'b1;
            bus.match_cnt <= '0;
        end else begin
            state         <= state_nxt;
            hist          <= hist_nxt;
            fill          <= fill_nxt;
            pat           <= pat_nxt;
            len           <= len_nxt;
            cnt           <= cnt_nxt;
`ifdef SEQ_DET_MASK_EN
            mask          <= mask_nxt;
`endif
            bus.w         <= w_nxt;
            bus.init      <= (state_nxt == HOLD);
            bus.en        <= (state_nxt == ARMED);
            bus.match_cnt <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_param_sequence_detector.sv
// Scoreboard bench for param_sequence_detector: directed scenarios plus random traffic
// checked cycle by cycle against a bit-queue reference model.
module tb_param_sequence_detector;
    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_sequence_detector_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    param_sequence_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit w;
        bit en;
        bit init;
        int cnt;
        int phase;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   phase    = 0;
    bit   done     = 1'b0;

    // Stimulus configuration applied on every step
    bit       ovl = 1'b0;
    bit       osh = 1'b0;
    bit [7:0] pin = 8'h00;
    bit [3:0] lin = 4'd0;
    bit [7:0] pmask = 8'hFF;

    // Reference model: bits received since the last clear, oldest first
    bit       m_bits[$];
    bit [7:0] m_pat;
    bit [7:0] m_mask;
    int       m_len;
    int       m_cnt;
    bit       m_armed;
    bit       m_w;

    function automatic void model_reset();
        m_bits.delete();
        m_pat   = 8'b0001_0110;
        m_mask  = 8'hFF;
        m_len   = 5;
        m_cnt   = 0;
        m_armed = 1'b1;
        m_w     = 1'b0;
    endfunction

    function automatic bit model_matches();
        int sz = m_bits.size();
        if (sz < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (m_mask[m_len-1-k] && (m_bits[sz-m_len+k] != m_pat[m_len-1-k]))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_step(input bit jb, input bit jv, input bit pl, input bit c);
        m_w = 1'b0;
        if (pl) begin
            m_pat = pin;
`ifdef SEQ_DET_MASK_EN
            m_mask = pmask;
`endif
            m_len   = (lin == 0) ? 1 : ((int'(lin) > 8) ? 8 : int'(lin));
            m_cnt   = 0;
            m_armed = 1'b1;
            m_bits.delete();
        end else if (c) begin
            m_armed = 1'b1;
            m_bits.delete();
        end else if (jv && m_armed) begin
            m_bits.push_back(jb);
            if (m_bits.size() > 8) void'(m_bits.pop_front());
            if (model_matches()) begin
                m_w   = 1'b1;
                m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                if (!ovl) m_bits.delete();
                if (osh) m_armed = 1'b0;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.w     = m_w;
        e.en    = m_armed;
        e.init  = !m_armed;
        e.cnt   = m_cnt;
        e.phase = phase;
        exp_q.push_back(e);
    endfunction

    // One clock of stimulus, driven at the falling edge
    task automatic step(input bit jb, input bit jv, input bit pl, input bit c);
        bus.j        = jb;
        bus.j_valid  = jv;
        bus.pat_load = pl;
        bus.co       = c;
        bus.overlap  = ovl;
        bus.one_shot = osh;
        bus.pat_in   = pin;
        bus.len_in   = lin;
`ifdef SEQ_DET_MASK_EN
        bus.pat_mask = pmask;
`endif
        model_step(jb, jv, pl, c);
        push_exp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.j = 1'b0; bus.j_valid = 1'b0; bus.pat_load = 1'b0; bus.co = 1'b0;
        bus.overlap = 1'b0; bus.one_shot = 1'b0; bus.pat_in = '0; bus.len_in = '0;
`ifdef SEQ_DET_MASK_EN
        bus.pat_mask = '1;
`endif
        rst = 1'b0;
        model_reset();
        push_exp();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Send n bits of val, most significant first, all valid
    task automatic send(input bit [15:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) step(val[i], 1'b1, 1'b0, 1'b0);
    endtask

    // Load a pattern; j_valid is held high to show the bit is discarded
    task automatic load(input bit [7:0] p, input bit [3:0] l);
        pin = p;
        lin = l;
        step(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: compare registered outputs one time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty t=%0t: DUT output with no expected entry", $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus.w !== e.w || bus.en !== e.en || bus.init !== e.init ||
                        bus.match_cnt !== CNT_W'(e.cnt)) begin
                        n_fail++;
                        $display("FAIL outputs phase=%0d t=%0t: got w=%b en=%b init=%b cnt=%0d, want w=%b en=%b init=%b cnt=%0d",
                                 e.phase, $time, bus.w, bus.en, bus.init, bus.match_cnt,
                                 e.w, e.en, e.init, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        phase = 1;  // default 10110
        send(16'b10110, 5);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        phase = 2;  // overlap on 101
        ovl = 1'b1;
        load(8'b101, 4'd3);
        send(16'b10101, 5);
        phase = 3;
        ovl = 1'b0;
        load(8'b101, 4'd3);
        send(16'b10101, 5);

        phase = 4;  // one-shot
        load(8'b0001_0110, 4'd5);
        osh = 1'b1;
        send(16'b10110, 5);
        send(16'b10110, 5);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        send(16'b10110, 5);
        osh = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1);

        phase = 5;  // length clamp
        load(8'b1, 4'd0);
        send(16'b1101, 4);
        load(8'hA5, 4'd12);
        send(16'hA5, 8);
        send(16'hA5, 8);

        phase = 6;  // gaps inside the pattern
        load(8'b0001_0110, 4'd5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        phase = 7;  // counter saturation
        ovl = 1'b1;
        load(8'b1, 4'd1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        ovl = 1'b0;

        phase = 8;  // reset mid-stream
        load(8'b1001, 4'd4);
        send(16'b101, 3);
        do_reset();
        send(16'b10, 2);
        send(16'b10110, 5);
        send(16'b101, 3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send(16'b0110, 4);
        send(16'b10110, 5);

        phase = 9;  // random traffic
        for (int i = 0; i < 1500; i++) begin
            bit pl, c;
            pl = ($urandom_range(39) == 0);
            c  = ($urandom_range(29) == 0);
            if ($urandom_range(19) == 0) ovl = ~ovl;
            if ($urandom_range(19) == 0) osh = ~osh;
            pin   = 8'($urandom);
            lin   = 4'($urandom_range(15));
            pmask = 8'($urandom);
            step(1'($urandom), ($urandom_range(3) != 0), pl, c);
        end

        done = 1'b1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
